// File: rtl/exa_crosb_input_vc_arbiter.sv
// Per-input-port VC arbiter: strict priority across classes, round-robin within a class,
// locked for a whole packet. Define EXA_CROSB_VC_AGING_EN to let starved low classes jump priority.
module exa_crosb_input_vc_arbiter #(
    parameter int prio_num   = 2,
    parameter int vc_num     = 2,
    parameter int output_num = 4,
    parameter int logVcPrio  = $clog2(prio_num * vc_num),
    parameter int logOutput  = $clog2(output_num),
    parameter int AGE_LIMIT  = 16
) (
    input  logic                                         M_ACLK,
    input  logic                                         M_ARESETN,
    input  logic [prio_num*vc_num-1:0]                   i_has_packet,
    input  logic [prio_num*vc_num-1:0][logOutput-1:0]    i_dests,
    input  logic [prio_num*vc_num-1:0][logVcPrio-1:0]    i_output_vc,
    input  logic [output_num*prio_num*vc_num-1:0]        i_out_vc_credit,
    input  logic                                         i_tvalid,
    input  logic                                         i_tready,
    input  logic                                         i_tlast,
    output logic [logVcPrio-1:0]                         o_selected_vc,
    output logic                                         o_cts,
    output logic                                         o_active,
    output logic [31:0]                                  o_grant_count
);

    localparam int NVC    = prio_num * vc_num;
    localparam int LOG_VC = (vc_num > 1) ? $clog2(vc_num) : 1;

    typedef enum logic {IDLE, XFER} state_t;

    state_t               state_q, state_d;
    logic [logVcPrio-1:0] sel_q, sel_d;
    logic [31:0]          cnt_q, cnt_d;
    logic [LOG_VC-1:0]    rr_q [prio_num];
    logic [LOG_VC-1:0]    rr_d [prio_num];

    logic [NVC-1:0]       eligible;
    logic [prio_num-1:0]  class_any;
    logic [LOG_VC-1:0]    class_pick [prio_num];
    int                   win_class;
    logic [logVcPrio-1:0] win_vc;
    int                   sel_class;
    int                   sel_idx;
    int                   idx;

`ifdef EXA_CROSB_VC_AGING_EN
    localparam int AGE_W = $clog2(AGE_LIMIT + 1);
    logic [AGE_W-1:0]     age_q [prio_num];
    logic [AGE_W-1:0]     age_d [prio_num];
`else
    wire unused_age_cfg = ^AGE_LIMIT;
`endif

    always_comb begin
        for (int v = 0; v < NVC; v++) begin
            eligible[v] = i_has_packet[v] &
                          i_out_vc_credit[int'(i_dests[v]) * NVC + int'(i_output_vc[v])];
        end

        // First eligible VC per class, scanning from that class's rr pointer
        idx = 0;
        for (int c = 0; c < prio_num; c++) begin
            class_any[c]  = 1'b0;
            class_pick[c] = '0;
            for (int k = 0; k < vc_num; k++) begin
                idx = (int'(rr_q[c]) + k) % vc_num;
                if (!class_any[c] && eligible[c * vc_num + idx]) begin
                    class_any[c]  = 1'b1;
                    class_pick[c] = LOG_VC'(idx);
                end
            end
        end

        win_class = 0;
        for (int c = 0; c < prio_num; c++) begin
            if (class_any[c]) win_class = c;
        end
`ifdef EXA_CROSB_VC_AGING_EN
        // Descending scan so the lowest aged, eligible class has the final say
        for (int c = prio_num - 2; c >= 0; c--) begin
            if (class_any[c] && age_q[c] == AGE_W'(AGE_LIMIT)) win_class = c;
        end
`endif
        win_vc = logVcPrio'(win_class * vc_num + int'(class_pick[win_class]));
    end

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        cnt_d     = cnt_q;
        rr_d      = rr_q;
        o_cts     = 1'b0;
        sel_class = int'(sel_q) / vc_num;
        sel_idx   = int'(sel_q) % vc_num;
`ifdef EXA_CROSB_VC_AGING_EN
        age_d     = age_q;
`endif
        case (state_q)
            IDLE: begin
                if (|eligible) begin
                    state_d = XFER;
                    sel_d   = win_vc;
                    cnt_d   = cnt_q + 32'd1;
`ifdef EXA_CROSB_VC_AGING_EN
                    for (int c = 0; c < prio_num - 1; c++) begin
                        if (win_class == c)
                            age_d[c] = '0;
                        else if (win_class > c && class_any[c] && age_q[c] != AGE_W'(AGE_LIMIT))
                            age_d[c] = age_q[c] + AGE_W'(1);
                    end
`endif
                end
            end
            XFER: begin
                o_cts = i_tvalid & i_tready;
                if (i_tvalid && i_tready && i_tlast) begin
                    state_d        = IDLE;
                    rr_d[sel_class] = LOG_VC'((sel_idx + 1) % vc_num);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge M_ACLK or negedge M_ARESETN) begin
        if (!M_ARESETN) begin
            state_q <= IDLE;
            sel_q   <= '0;
            cnt_q   <= '0;
            for (int c = 0; c < prio_num; c++) rr_q[c] <= '0;
`ifdef EXA_CROSB_VC_AGING_EN
            for (int c = 0; c < prio_num; c++) age_q[c] <= '0;
`endif
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            rr_q    <= rr_d;
`ifdef EXA_CROSB_VC_AGING_EN
            age_q   <= age_d;
`endif
        end
    end

    assign o_selected_vc = sel_q;
    assign o_active      = (state_q == XFER);
    assign o_grant_count = cnt_q;

endmodule

// File: doc/exa_crosb_input_vc_arbiter.md
Name: exa_crosb_input_vc_arbiter

Overview:
Per-input-port VC arbiter that sits directly downstream of the e2s VC FIFO stage.
- Watches the per-VC head-of-line status: has_packet, destination port, output VC.
- Picks one VC whose target output VC has a credit, and locks onto it for a whole packet.
- Drives the select and dequeue (cts) lines back into the e2s FIFO bank.
- The e2s M_AXIS stream, muxed by this select, feeds the crossbar.

Parameters:
- prio_num, 2, number of priority classes; class index j = vc_index / vc_num; higher j = higher priority.
- vc_num, 2, VCs per priority class.
- output_num, 4, number of crossbar output ports.
- logVcPrio, log2(prio_num*vc_num), width of a VC index.
- logOutput, log2(output_num), width of a destination index.
- AGE_LIMIT, 16, lost arbitrations before a starved low class is forced; used only with the optional feature.

Ports:
- M_ACLK  in  1  clock.
- M_ARESETN  in  1  reset; asynchronous assert, active-low.
- i_has_packet  in  prio_num*vc_num  per-VC FIFO non-empty.
- i_dests  in  [prio_num*vc_num] x logOutput  head-of-line destination per VC.
- i_output_vc  in  [prio_num*vc_num] x logVcPrio  head-of-line output VC per VC.
- i_out_vc_credit  in  output_num*prio_num*vc_num  credit-available bitmap; bit index = dest*(prio_num*vc_num)+output_vc.
- i_tvalid  in  1  M_AXIS.TVALID of the selected VC.
- i_tready  in  1  crossbar TREADY.
- i_tlast  in  1  M_AXIS.TLAST of the selected VC.
- o_selected_vc  out  logVcPrio  VC select into the e2s mux.
- o_cts  out  1  dequeue strobe for the selected FIFO.
- o_active  out  1  a packet is locked.
- o_grant_count  out  32  number of packets granted since reset.

Behaviour:
- Eligibility: eligible[v] = i_has_packet[v] & i_out_vc_credit[i_dests[v]*(prio_num*vc_num)+i_output_vc[v]].
- Arbitration policy:
  - Strict priority across classes: the highest class with any eligible VC wins.
  - Round-robin within a class, using one rr pointer per class (logVc bits).
  - Search order starts at the pointer and wraps modulo vc_num.
- FSM has two states:
  - IDLE: if any VC is eligible, register the winner into o_selected_vc, set o_active=1, increment o_grant_count (wraps at 2^32), and go to XFER. Latency is one cycle from eligibility to o_active.
  - XFER: o_cts = i_tvalid & i_tready, combinational. On a cycle with i_tvalid & i_tready & i_tlast, go to IDLE, clear o_active, and set the winner class's rr pointer to (winner_vc_in_class+1) mod vc_num.
  - In IDLE, o_cts = 0.
- Minimum gap: one IDLE cycle between back-to-back packets. A packet of N beats occupies at least N+1 cycles.
- Lock: selection does not change during XFER.
  - Credit or has_packet dropping mid-packet is ignored; the block simply waits while i_tvalid is low.
  - Credit is sampled only at grant.
- Single-beat packet: the tlast handshake on the first XFER cycle returns the FSM to IDLE on the next cycle.
- No eligible VC: the FSM stays in IDLE and o_selected_vc holds its last value.
- Reset values: state=IDLE, o_selected_vc=0, o_active=0, o_cts=0, o_grant_count=0, all rr pointers=0, all age counters=0.
- Reset asserted mid-packet: the FSM aborts to IDLE immediately. The e2s stage is reset by the same signal, so no FIFO cleanup is needed.
- X-safety: i_tlast is ignored in IDLE.

Optional Feature:
- Macro: EXA_CROSB_VC_AGING_EN.
- Defined:
  - Each class below the top class keeps a counter, saturating at AGE_LIMIT.
  - The counter increments on every grant to a higher class while that class had an eligible VC, and clears when that class is granted.
  - When a counter equals AGE_LIMIT and its class is eligible, that class beats strict priority. If several classes are aged, the lowest wins.
- Undefined: pure strict priority; the counters are not instantiated.

Test Plan:
- Only VC1 (class 0) has_packet with credit, 3-beat packet, tready=1:
  - o_active rises 1 cycle later with o_selected_vc=1.
  - o_cts is high for 3 cycles, then o_active=0 and o_grant_count=1.
- VC0 and VC2 both eligible → VC2 (high class) is granted first; VC0 is granted after VC2's tlast, with one IDLE cycle between.
- VC0 and VC1 both continuously eligible with 1-beat packets → grants alternate 0,1,0,1.
- VC3 has_packet but its credit bit is 0 → no grant. Raising the credit produces a grant 1 cycle later. Dropping the credit mid-packet keeps the lock until tlast.
- Mid-packet i_tready=0 for 4 cycles → o_cts stays 0 and the selection holds. M_ARESETN pulsed low mid-packet → o_active=0 and o_selected_vc=0 immediately.
- With EXA_CROSB_VC_AGING_EN and AGE_LIMIT=16: VC0 and VC2 are both always eligible → VC0 is granted on the 17th grant.
